serial_receiver: RTL and testbench

- Far end of the calculator's serial output link; reconstructs 32-bit words from the DataOut / DOutValid / ClkTx stream produced by the serial transceiver.
- Used as the bench-side and loopback receiver, and as the front end of the next-stage consumer.
- Deserializes SIZE bits per ClkTx rising edge and presents the completed word plus its decoded calculator fields (A, B, result, select, flags).
- Flags a truncated frame.

---
 rtl/serial_pkg.sv | 24 ++
 rtl/serial_receiver_edge_detect.sv | 21 ++
 rtl/serial_receiver.sv | 132 +++++++++++++
 tb/tb_serial_receiver.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared word geometry, calculator field layout and receiver state encoding
// for the serial link receiver.
package serial_pkg;

  localparam int WORD_W   = 32;

  localparam int A_LSB    = 24;
  localparam int A_W      = 8;
  localparam int B_LSB    = 16;
  localparam int B_W      = 8;
  localparam int RES_LSB  = 8;
  localparam int RES_W    = 8;
  localparam int SEL_LSB  = 4;
  localparam int SEL_W    = 4;
  localparam int FLAG_LSB = 0;
  localparam int FLAG_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } rx_state_t;

endpackage

// File: rtl/serial_receiver_edge_detect.sv
// One-register edge detector in the Clk domain; the history register resets
// to 0, so a line already high at reset release reads as a rise.
module edge_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic In,
  output logic Rise,
  output logic Fall
);

  logic in_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) in_q <= 1'b0;
    else        in_q <= In;
  end

  assign Rise = In & ~in_q;
  assign Fall = ~In & in_q;

endmodule

// File: rtl/serial_receiver.sv
// Deserializes SIZE-bit beats (MSB first) taken on ClkTx rises into 32-bit
// words, decodes the calculator fields and flags truncated frames.
module serial_receiver
  import serial_pkg::*;
#(
  parameter int SIZE = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Enable,
  input  logic              ClkTx,
  input  logic              DinValid,
  input  logic [SIZE-1:0]   Din,
  output logic [WORD_W-1:0] WordOut,
  output logic [A_W-1:0]    RxA,
  output logic [B_W-1:0]    RxB,
  output logic [RES_W-1:0]  RxResult,
  output logic [SEL_W-1:0]  RxSel,
  output logic [FLAG_W-1:0] RxFlag,
  output logic              WordValid,
  output logic              FrameError,
  output logic              RxBusy
);

  localparam int BEATS = WORD_W / SIZE;
  localparam int CNT_W = $clog2(BEATS) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  // Edge detectors: lane 0 watches ClkTx, lane 1 watches DinValid.
  logic [1:0] ed_in, ed_rise, ed_fall;
  assign ed_in = {DinValid, ClkTx};

  for (genvar g = 0; g < 2; g++) begin : g_edge
    edge_detect u_edge (
      .Clk   (Clk),
      .Reset (Reset),
      .In    (ed_in[g]),
      .Rise  (ed_rise[g]),
      .Fall  (ed_fall[g])
    );
  end

  logic tx_edge, dv_fall;
  logic unused_edges;
  assign tx_edge      = ed_rise[0];
  assign dv_fall      = ed_fall[1];
  assign unused_edges = ^{ed_rise[1], ed_fall[0]};

  rx_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              ferr_q, ferr_d;

  logic              beat, last, abort;
  logic [WORD_W-1:0] shift_nxt;

  assign beat      = tx_edge & DinValid & Enable;
  assign last      = (cnt_q == LAST);
  // Only a partially received word can be truncated; DONE/IDLE just drop out.
  assign abort     = (state_q == SHIFT) & (dv_fall | ~Enable);
  assign shift_nxt = WORD_W'({shift_q, Din});

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (beat) state_d = last ? DONE : SHIFT;
      SHIFT: begin
        if (abort)             state_d = IDLE;
        else if (beat && last) state_d = DONE;
      end
      DONE:    state_d = beat ? (last ? DONE : SHIFT) : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    WordValid = 1'b0;
    RxBusy    = 1'b0;
    case (state_q)
      SHIFT:   RxBusy    = 1'b1;
      DONE:    WordValid = 1'b1;
      default: ;
    endcase
  end

  // The finished word is latched on the last beat so it lands with WordValid.
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    word_d  = word_q;
    ferr_d  = abort;
    if (abort) begin
      cnt_d = '0;
    end else if (beat) begin
      shift_d = shift_nxt;
      cnt_d   = last ? '0 : cnt_q + CNT_W'(1);
      if (last) word_d = shift_nxt;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      ferr_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      ferr_q  <= ferr_d;
    end
  end

  assign WordOut    = word_q;
  assign FrameError = ferr_q;
  assign RxA        = word_q[A_LSB    +: A_W];
  assign RxB        = word_q[B_LSB    +: B_W];
  assign RxResult   = word_q[RES_LSB  +: RES_W];
  assign RxSel      = word_q[SEL_LSB  +: SEL_W];
  assign RxFlag     = word_q[FLAG_LSB +: FLAG_W];

  a_cnt_range: assert property (@(posedge Clk) disable iff (!Reset) cnt_q <= LAST);
  a_vld_busy:  assert property (@(posedge Clk) disable iff (!Reset) !(WordValid && RxBusy));

endmodule

// File: tb/tb_serial_receiver.sv
// Drives one shared ClkTx/DinValid stream into receivers of SIZE 1, 4 and 8
// and checks every cycle against a word-level model plus directed scenarios.
module tb_serial_receiver;

  localparam int NS = 3;

  logic       Clk = 1'b0;
  logic       Reset, Enable, ClkTx, DinValid;
  logic [0:0] d1;
  logic [3:0] d4;
  logic [7:0] d8;

  logic [31:0] wo [NS];
  logic [7:0]  ra [NS], rb [NS], rr [NS];
  logic [3:0]  rs [NS], rf [NS];
  logic        wv [NS], fe [NS], bz [NS];

  always #5 Clk = ~Clk;

  serial_receiver #(.SIZE(1)) u_s1 (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .ClkTx(ClkTx), .DinValid(DinValid), .Din(d1),
    .WordOut(wo[0]), .RxA(ra[0]), .RxB(rb[0]), .RxResult(rr[0]), .RxSel(rs[0]), .RxFlag(rf[0]),
    .WordValid(wv[0]), .FrameError(fe[0]), .RxBusy(bz[0]));
  serial_receiver #(.SIZE(4)) u_s4 (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .ClkTx(ClkTx), .DinValid(DinValid), .Din(d4),
    .WordOut(wo[1]), .RxA(ra[1]), .RxB(rb[1]), .RxResult(rr[1]), .RxSel(rs[1]), .RxFlag(rf[1]),
    .WordValid(wv[1]), .FrameError(fe[1]), .RxBusy(bz[1]));
  serial_receiver #(.SIZE(8)) u_s8 (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .ClkTx(ClkTx), .DinValid(DinValid), .Din(d8),
    .WordOut(wo[2]), .RxA(ra[2]), .RxB(rb[2]), .RxResult(rr[2]), .RxSel(rs[2]), .RxFlag(rf[2]),
    .WordValid(wv[2]), .FrameError(fe[2]), .RxBusy(bz[2]));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int sz_of(input int s);
    case (s)
      0:       return 1;
      1:       return 4;
      default: return 8;
    endcase
  endfunction

  function automatic logic [31:0] din_of(input int s);
    case (s)
      0:       return {31'b0, d1};
      1:       return {28'b0, d4};
      default: return {24'b0, d8};
    endcase
  endfunction

  // Word-level reference: beats accumulate MSB first; a full word publishes
  // next cycle; losing DinValid or Enable mid-word discards it with an error.
  logic [31:0] m_acc [NS], m_word [NS];
  int          m_cnt [NS];
  logic        m_wv [NS], m_fe [NS];
  logic        m_ctx_p, m_dv_p, m_beat;
  int          m_sz;

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int s = 0; s < NS; s++) begin
        m_acc[s] = '0; m_word[s] = '0; m_cnt[s] = 0; m_wv[s] = 1'b0; m_fe[s] = 1'b0;
      end
      m_ctx_p = 1'b0;
      m_dv_p  = 1'b0;
    end else begin
      m_beat = ClkTx && !m_ctx_p && DinValid && Enable;
      for (int s = 0; s < NS; s++) begin
        m_sz    = sz_of(s);
        m_wv[s] = 1'b0;
        m_fe[s] = 1'b0;
        if (m_cnt[s] > 0 && ((m_dv_p && !DinValid) || !Enable)) begin
          m_fe[s]  = 1'b1;
          m_cnt[s] = 0;
        end else if (m_beat) begin
          m_acc[s] = (m_acc[s] << m_sz) | din_of(s);
          m_cnt[s] = m_cnt[s] + 1;
          if (m_cnt[s] == 32 / m_sz) begin
            m_word[s] = m_acc[s];
            m_wv[s]   = 1'b1;
            m_cnt[s]  = 0;
          end
        end
      end
      m_ctx_p = ClkTx;
      m_dv_p  = DinValid;
    end
  end

  int cnt_wv [NS], cnt_fe [NS], cnt_bz [NS];

  always @(negedge Clk) begin
    for (int s = 0; s < NS; s++) begin
      chk($sformatf("s%0d.WordOut", sz_of(s)),   wo[s], m_word[s]);
      chk($sformatf("s%0d.WordValid", sz_of(s)), {31'b0, wv[s]}, {31'b0, m_wv[s]});
      chk($sformatf("s%0d.FrameError", sz_of(s)), {31'b0, fe[s]}, {31'b0, m_fe[s]});
      chk($sformatf("s%0d.RxBusy", sz_of(s)),    {31'b0, bz[s]}, {31'b0, (m_cnt[s] != 0)});
      chk($sformatf("s%0d.fields", sz_of(s)), {ra[s], rb[s], rr[s], rs[s], rf[s]}, m_word[s]);
      if (wv[s]) cnt_wv[s]++;
      if (fe[s]) cnt_fe[s]++;
      if (bz[s]) cnt_bz[s]++;
    end
  end

  // One ClkTx period starting at a negedge; target lane carries beat i of w.
  task automatic slot(input int hi, input int lo);
    ClkTx = 1'b1;
    repeat (hi) @(negedge Clk);
    ClkTx = 1'b0;
    repeat (lo) @(negedge Clk);
  endtask

  task automatic send_beat(input int s, input logic [31:0] w, input int i);
    logic [31:0] v;
    d1 = 1'($urandom); d4 = 4'($urandom); d8 = 8'($urandom);
    v  = w >> (32 - (i + 1) * sz_of(s));
    case (s)
      0:       d1 = v[0];
      1:       d4 = v[3:0];
      default: d8 = v[7:0];
    endcase
    slot(2, 2);
  endtask

  task automatic send_word(input int s, input logic [31:0] w);
    DinValid = 1'b1;
    for (int i = 0; i < 32 / sz_of(s); i++) send_beat(s, w, i);
  endtask

  task automatic end_frame();
    DinValid = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  int b_wv [NS], b_fe [NS], b_bz [NS];

  task automatic snap();
    for (int s = 0; s < NS; s++) begin
      b_wv[s] = cnt_wv[s]; b_fe[s] = cnt_fe[s]; b_bz[s] = cnt_bz[s];
    end
  endtask

  initial begin
    Reset = 1'b0; Enable = 1'b1; ClkTx = 1'b0; DinValid = 1'b0;
    d1 = '0; d4 = '0; d8 = '0;
    repeat (3) @(negedge Clk);
    for (int s = 0; s < NS; s++) chk("reset.WordOut", wo[s], 32'h0);
    Reset = 1'b1;
    @(negedge Clk);

    // SIZE=1 single word
    snap();
    send_word(0, 32'hA53CE194);
    end_frame();
    chk("t1.word", wo[0], 32'hA53CE194);
    chk("t1.RxA", {24'b0, ra[0]}, 32'hA5);
    chk("t1.RxB", {24'b0, rb[0]}, 32'h3C);
    chk("t1.RxResult", {24'b0, rr[0]}, 32'hE1);
    chk("t1.RxSel", {28'b0, rs[0]}, 32'h9);
    chk("t1.RxFlag", {28'b0, rf[0]}, 32'h4);
    chk("t1.pulses", cnt_wv[0] - b_wv[0], 1);
    chk("t1.ferr", cnt_fe[0] - b_fe[0], 0);

    // SIZE=8 word, busy spans three 4-cycle ClkTx periods
    snap();
    send_word(2, 32'h12345678);
    end_frame();
    chk("t2.word", wo[2], 32'h12345678);
    chk("t2.pulses", cnt_wv[2] - b_wv[2], 1);
    chk("t2.busy_cycles", cnt_bz[2] - b_bz[2], 12);

    // SIZE=1 truncation after 17 beats, then a clean word
    snap();
    DinValid = 1'b1;
    for (int i = 0; i < 17; i++) send_beat(0, 32'h5555AAAA, i);
    end_frame();
    chk("t3.ferr", cnt_fe[0] - b_fe[0], 1);
    chk("t3.hold", wo[0], 32'hA53CE194);
    chk("t3.no_pulse", cnt_wv[0] - b_wv[0], 0);
    send_word(0, 32'h0000FFFF);
    end_frame();
    chk("t3.word", wo[0], 32'h0000FFFF);

    // SIZE=4 back-to-back
    snap();
    DinValid = 1'b1;
    for (int i = 0; i < 8; i++) send_beat(1, 32'hDEADBEEF, i);
    chk("t4.first", wo[1], 32'hDEADBEEF);
    for (int i = 0; i < 8; i++) send_beat(1, 32'hCAFEF00D, i);
    end_frame();
    chk("t4.second", wo[1], 32'hCAFEF00D);
    chk("t4.pulses", cnt_wv[1] - b_wv[1], 2);
    chk("t4.ferr", cnt_fe[1] - b_fe[1], 0);

    // Async reset mid-frame
    DinValid = 1'b1;
    for (int i = 0; i < 10; i++) send_beat(0, 32'hFFFFFFFF, i);
    DinValid = 1'b0;
    #2 Reset = 1'b0;
    #1;
    for (int s = 0; s < NS; s++) begin
      chk("t5.rst_word", wo[s], 32'h0);
      chk("t5.rst_flags", {29'b0, wv[s], fe[s], bz[s]}, 32'h0);
    end
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    snap();
    send_word(0, 32'h01020304);
    end_frame();
    chk("t5.word", wo[0], 32'h01020304);
    chk("t5.pulses", cnt_wv[0] - b_wv[0], 1);

    // Noise: edges without DinValid, then a valid stream with Enable low
    snap();
    for (int i = 0; i < 20; i++) begin
      d1 = 1'($urandom); d4 = 4'($urandom); d8 = 8'($urandom);
      slot(2, 2);
    end
    Enable = 1'b0;
    send_word(0, 32'h87654321);
    end_frame();
    Enable = 1'b1;
    @(negedge Clk);
    for (int s = 0; s < NS; s++) begin
      chk("t6.no_pulse", cnt_wv[s] - b_wv[s], 0);
      chk("t6.no_busy", cnt_bz[s] - b_bz[s], 0);
      chk("t6.no_ferr", cnt_fe[s] - b_fe[s], 0);
    end

    // Randomized stream: varying ClkTx period, DinValid gaps, Enable drops
    for (int i = 0; i < 400; i++) begin
      DinValid = ($urandom_range(11) != 0);
      Enable   = ($urandom_range(19) != 0);
      d1 = 1'($urandom); d4 = 4'($urandom); d8 = 8'($urandom);
      slot($urandom_range(3, 1), $urandom_range(3, 1));
    end
    DinValid = 1'b0;
    Enable   = 1'b1;
    repeat (4) @(negedge Clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
